// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared types and constants for the layer sequencer.
// Holds the sequencer state encoding, the datapath wire-connect codes and a
// small helper that sizes counters so they can hold their full range.
package layer_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRELOAD   = 3'd1,
        L0_NORMAL = 3'd2,
        L0_ROUND  = 3'd3,
        LN_NORMAL = 3'd4,
        LN_ROUND  = 3'd5,
        DRAIN     = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Datapath routing selects driven on wire_connect_o.
    localparam logic [1:0] WC_L0   = 2'd0;
    localparam logic [1:0] WC_LOAD = 2'd1;
    localparam logic [1:0] WC_LN   = 2'd2;
    localparam logic [1:0] WC_IDLE = 2'd3;

    // Bits needed to hold values 0..n (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_counter.sv
// seq_counter: wrapping up-counter used for beats, rows, layers and rounds.
// Counts 0..TERMINAL; term is high while the count sits on TERMINAL so the
// owner can detect the last step. clr has priority over en.
module seq_counter
    import layer_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);

    assign term = (count == TERM_VAL);

    // Advance on en, wrap to zero after the terminal value, clear on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= term ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: multi-layer sequencer for the PE-array datapath.
// Runs weight preload, first-layer streaming (valid/ready), round phases,
// internal-buffer layers and a backpressured output drain.
// Optional build macro LAYER_SEQ_PERF_CNT_EN adds stall_cnt_o, a saturating
// count of cycles spent waiting on a handshake partner.
module layer_seq_ctrl
    import layer_seq_pkg::*;
#(
    parameter int NUM_LAYERS     = 8,
    parameter int ROWS_PER_LAYER = 16,
    parameter int BEATS_PER_ROW  = 8,
    parameter int ROUND_CYCLES   = 8,
    parameter int PRELOAD_BEATS  = 2,
    parameter int OUT_BEATS      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic                              data_vld_i,
    output logic                              data_rdy_o,
    output logic                              read_en_o,
    output logic [1:0]                        wire_connect_o,
    output logic                              acc_clr_o,
    output logic                              out_vld_o,
    input  logic                              out_rdy_i,
    output logic [$clog2(NUM_LAYERS+1)-1:0]   layer_idx_o,
    output logic [$clog2(ROWS_PER_LAYER+1)-1:0] row_idx_o,
    output logic                              busy_o,
    output logic                              done_o
`ifdef LAYER_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                       stall_cnt_o
`endif
);

    localparam int LW = $clog2(NUM_LAYERS + 1);
    localparam int RW = $clog2(ROWS_PER_LAYER + 1);
    localparam int BW = cnt_width(BEATS_PER_ROW);
    localparam int CW = cnt_width(ROUND_CYCLES);
    localparam int PW = cnt_width(PRELOAD_BEATS);
    localparam int OW = cnt_width(OUT_BEATS);
    localparam bit MULTI_LAYER = (NUM_LAYERS > 1);

    state_t state_q;
    state_t state_d;
    logic   entered_q;

    logic          data_xfer;
    logic          out_xfer;
    logic          phase_clr;
    logic          layer_clr;
    logic          beat_en, row_en, layer_en, round_en, pre_en, out_en;
    logic          beat_term, row_term, layer_term, round_term, pre_term, out_term;
    logic [BW-1:0] beat_cnt;
    logic [RW-1:0] row_cnt;
    logic [LW-1:0] layer_cnt;
    logic [CW-1:0] round_cnt;
    logic [PW-1:0] pre_cnt;
    logic [OW-1:0] out_cnt;
    logic          unused_cnt_bits;

    assign data_xfer = data_vld_i & data_rdy_o;
    assign out_xfer  = out_vld_o & out_rdy_i;

    // Phase-local counters restart whenever the state changes.
    assign phase_clr = (state_d != state_q);
    assign layer_clr = (state_q == IDLE) && start_i;

    assign pre_en   = (state_q == PRELOAD) && data_xfer;
    assign beat_en  = ((state_q == L0_NORMAL) && data_xfer) || (state_q == LN_NORMAL);
    assign row_en   = beat_en && beat_term;
    assign round_en = (state_q == L0_ROUND) || (state_q == LN_ROUND);
    assign out_en   = (state_q == DRAIN) && out_xfer;
    assign layer_en = round_term &&
                      (((state_q == L0_ROUND) && MULTI_LAYER) ||
                       ((state_q == LN_ROUND) && !layer_term));

    seq_counter #(.WIDTH(BW), .TERMINAL(BEATS_PER_ROW - 1)) u_beat_cnt (
        .clk(clk), .rst(rst), .en(beat_en), .clr(phase_clr),
        .count(beat_cnt), .term(beat_term)
    );

    seq_counter #(.WIDTH(RW), .TERMINAL(ROWS_PER_LAYER - 1)) u_row_cnt (
        .clk(clk), .rst(rst), .en(row_en), .clr(phase_clr),
        .count(row_cnt), .term(row_term)
    );

    seq_counter #(.WIDTH(LW), .TERMINAL(NUM_LAYERS - 1)) u_layer_cnt (
        .clk(clk), .rst(rst), .en(layer_en), .clr(layer_clr),
        .count(layer_cnt), .term(layer_term)
    );

    seq_counter #(.WIDTH(CW), .TERMINAL(ROUND_CYCLES - 1)) u_round_cnt (
        .clk(clk), .rst(rst), .en(round_en), .clr(phase_clr),
        .count(round_cnt), .term(round_term)
    );

    seq_counter #(.WIDTH(PW), .TERMINAL(PRELOAD_BEATS - 1)) u_pre_cnt (
        .clk(clk), .rst(rst), .en(pre_en), .clr(phase_clr),
        .count(pre_cnt), .term(pre_term)
    );

    seq_counter #(.WIDTH(OW), .TERMINAL(OUT_BEATS - 1)) u_out_cnt (
        .clk(clk), .rst(rst), .en(out_en), .clr(phase_clr),
        .count(out_cnt), .term(out_term)
    );

    // Only the terminal flags of these counters matter to the sequencer.
    assign unused_cnt_bits = ^{beat_cnt, round_cnt, pre_cnt, out_cnt};

    // State register plus a flag marking the first cycle after any state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            entered_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            entered_q <= phase_clr;
        end
    end

    // Next-state and output decode from the registered state and counter flags.
    always_comb begin
        state_d        = state_q;
        data_rdy_o     = 1'b0;
        read_en_o      = 1'b0;
        wire_connect_o = WC_IDLE;
        out_vld_o      = 1'b0;
        done_o         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = PRELOAD;
            end
            PRELOAD: begin
                data_rdy_o     = 1'b1;
                wire_connect_o = WC_LOAD;
                read_en_o      = data_vld_i;
                if (data_vld_i && pre_term) state_d = L0_NORMAL;
            end
            L0_NORMAL: begin
                data_rdy_o     = 1'b1;
                wire_connect_o = WC_L0;
                read_en_o      = data_vld_i;
                if (data_vld_i && beat_term && row_term) state_d = L0_ROUND;
            end
            L0_ROUND: begin
                if (round_term) state_d = MULTI_LAYER ? LN_NORMAL : DRAIN;
            end
            LN_NORMAL: begin
                read_en_o      = 1'b1;
                wire_connect_o = WC_LN;
                if (beat_term && row_term) state_d = LN_ROUND;
            end
            LN_ROUND: begin
                if (round_term) state_d = layer_term ? DRAIN : LN_NORMAL;
            end
            DRAIN: begin
                out_vld_o = 1'b1;
                if (out_rdy_i && out_term) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign acc_clr_o   = entered_q && ((state_q == L0_NORMAL) || (state_q == LN_NORMAL));
    assign busy_o      = (state_q != IDLE);
    assign layer_idx_o = layer_cnt;
    assign row_idx_o   = row_cnt;

`ifdef LAYER_SEQ_PERF_CNT_EN
    logic stall_cond;

    assign stall_cond = (((state_q == PRELOAD) || (state_q == L0_NORMAL)) && !data_vld_i) ||
                        ((state_q == DRAIN) && !out_rdy_i);

    // Saturating stall counter, cleared when a new sequence is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            stall_cnt_o <= '0;
        end else if (stall_cond && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: self-checking bench for layer_seq_ctrl.
// Main instance uses NUM_LAYERS=2, ROWS=2, BEATS=4, ROUND=3, PRELOAD=2, OUT=2;
// a second instance with NUM_LAYERS=1 covers the single-layer path.
module tb_layer_seq_ctrl;

    localparam int NL  = 2;
    localparam int RPL = 2;
    localparam int BPR = 4;
    localparam int RC  = 3;
    localparam int PB  = 2;
    localparam int OB  = 2;

    logic clk = 1'b0;
    logic rst;
    logic start, start1;
    logic data_vld, out_rdy;

    logic                         data_rdy, read_en, acc_clr, out_vld, busy, done;
    logic [1:0]                   wire_conn;
    logic [$clog2(NL+1)-1:0]      layer_idx;
    logic [$clog2(RPL+1)-1:0]     row_idx;
    logic                         data_rdy1, read_en1, acc_clr1, out_vld1, busy1, done1;
    logic [1:0]                   wire_conn1;
    logic [$clog2(2)-1:0]         layer_idx1;
    logic [$clog2(RPL+1)-1:0]     row_idx1;
`ifdef LAYER_SEQ_PERF_CNT_EN
    logic [31:0]                  stall_cnt, stall_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_seq_ctrl #(
        .NUM_LAYERS(NL), .ROWS_PER_LAYER(RPL), .BEATS_PER_ROW(BPR),
        .ROUND_CYCLES(RC), .PRELOAD_BEATS(PB), .OUT_BEATS(OB)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .data_vld_i(data_vld),
        .data_rdy_o(data_rdy), .read_en_o(read_en), .wire_connect_o(wire_conn),
        .acc_clr_o(acc_clr), .out_vld_o(out_vld), .out_rdy_i(out_rdy),
        .layer_idx_o(layer_idx), .row_idx_o(row_idx), .busy_o(busy), .done_o(done)
`ifdef LAYER_SEQ_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    layer_seq_ctrl #(
        .NUM_LAYERS(1), .ROWS_PER_LAYER(RPL), .BEATS_PER_ROW(BPR),
        .ROUND_CYCLES(RC), .PRELOAD_BEATS(PB), .OUT_BEATS(OB)
    ) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .data_vld_i(data_vld),
        .data_rdy_o(data_rdy1), .read_en_o(read_en1), .wire_connect_o(wire_conn1),
        .acc_clr_o(acc_clr1), .out_vld_o(out_vld1), .out_rdy_i(out_rdy),
        .layer_idx_o(layer_idx1), .row_idx_o(row_idx1), .busy_o(busy1), .done_o(done1)
`ifdef LAYER_SEQ_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt1)
`endif
    );

    // Expected wire_connect per cycle of a full unstalled run (start in cycle 0).
    function automatic logic [1:0] spec_wire(input int c);
        if (c >= 1 && c <= 2)   return 2'd1;
        if (c >= 3 && c <= 10)  return 2'd0;
        if (c >= 14 && c <= 21) return 2'd2;
        return 2'd3;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({busy, data_rdy, read_en, acc_clr, out_vld, done} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got=%b exp=000000",
                     {busy, data_rdy, read_en, acc_clr, out_vld, done});
        end
        checks++;
        if (wire_conn !== 2'd3 || wire_conn1 !== 2'd3) begin
            errors++;
            $display("[TB] FAIL reset_wire got=%0d/%0d exp=3", wire_conn, wire_conn1);
        end
        checks++;
        if (layer_idx !== '0 || row_idx !== '0) begin
            errors++;
            $display("[TB] FAIL reset_idx got layer=%0d row=%0d exp=0", layer_idx, row_idx);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dut1 got busy=%b done=%b exp=0", busy1, done1);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got busy=%b exp=0", busy);
        end
    endtask

    // Full run with data_vld and out_rdy held high; optional stray start pulse.
    task automatic test_nominal(input int spurious_cyc, input string tag);
        logic [1:0] exp_wire_q[$];
        int         exp_clr_q[$];
        int         exp_done_q[$];
        logic [1:0] ew;
        int         e;
        int         rd_cnt = 0;
        int         ov_cnt = 0;
        exp_clr_q.push_back(3);
        exp_clr_q.push_back(14);
        exp_done_q.push_back(27);
        for (int c = 0; c <= 28; c++) begin
            @(posedge clk);
            #1;
            start    = (c == 0) || (c == spurious_cyc);
            data_vld = 1'b1;
            out_rdy  = 1'b1;
            exp_wire_q.push_back(spec_wire(c));
            #1;
            ew = exp_wire_q.pop_front();
            checks++;
            if (wire_conn !== ew) begin
                errors++;
                $display("[TB] FAIL %s wire cyc=%0d got=%0d exp=%0d", tag, c, wire_conn, ew);
            end
            if (acc_clr === 1'b1) begin
                checks++;
                if (exp_clr_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s acc_clr cyc=%0d got=1 exp=0", tag, c);
                end else begin
                    e = exp_clr_q.pop_front();
                    if (c != e) begin
                        errors++;
                        $display("[TB] FAIL %s acc_clr_cycle got=%0d exp=%0d", tag, c, e);
                    end
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s done cyc=%0d got=1 exp=0", tag, c);
                end else begin
                    e = exp_done_q.pop_front();
                    if (c != e) begin
                        errors++;
                        $display("[TB] FAIL %s done_cycle got=%0d exp=%0d", tag, c, e);
                    end
                end
            end
            if (read_en === 1'b1) rd_cnt++;
            if (out_vld === 1'b1) ov_cnt++;
            if (c >= 14 && c <= 21) begin
                checks++;
                if (data_rdy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s ln_rdy cyc=%0d got=%b exp=0", tag, c, data_rdy);
                end
            end
            if (c == 6 || c == 7 || c == 17 || c == 18) begin
                checks++;
                if (row_idx !== ((c == 6 || c == 17) ? 2'd0 : 2'd1)) begin
                    errors++;
                    $display("[TB] FAIL %s row cyc=%0d got=%0d", tag, c, row_idx);
                end
            end
            if (c == 10 || c == 14 || c == 25) begin
                checks++;
                if (layer_idx !== ((c == 10) ? 2'd0 : 2'd1)) begin
                    errors++;
                    $display("[TB] FAIL %s layer cyc=%0d got=%0d", tag, c, layer_idx);
                end
            end
            if (c == 27 || c == 28) begin
                checks++;
                if (busy !== (c == 27)) begin
                    errors++;
                    $display("[TB] FAIL %s busy cyc=%0d got=%b exp=%b", tag, c, busy, c == 27);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (exp_clr_q.size() != 0 || exp_done_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s missing_pulses got clr_left=%0d done_left=%0d exp=0",
                     tag, exp_clr_q.size(), exp_done_q.size());
        end
        checks++;
        if (rd_cnt != 18) begin
            errors++;
            $display("[TB] FAIL %s read_en_count got=%0d exp=18", tag, rd_cnt);
        end
        checks++;
        if (ov_cnt != 2) begin
            errors++;
            $display("[TB] FAIL %s out_vld_count got=%0d exp=2", tag, ov_cnt);
        end
    endtask

    // data_vld alternates 0,1 through L0_NORMAL; transfers land on even cycles 4..18.
    task automatic test_vld_toggle();
        logic exp_rd_q[$];
        logic er;
        int   l0_cycles = 0;
        int   done_cyc  = -1;
        for (int c = 0; c <= 36; c++) begin
            @(posedge clk);
            #1;
            start    = (c == 0);
            out_rdy  = 1'b1;
            data_vld = (c <= 2) ? 1'b1 : (((c - 3) % 2) == 1);
            if (c <= 29)
                exp_rd_q.push_back((c >= 1 && c <= 2) || (c >= 22) ||
                                   (c >= 3 && c <= 18 && ((c - 3) % 2) == 1));
            #1;
            if (c <= 29) begin
                er = exp_rd_q.pop_front();
                checks++;
                if (read_en !== er) begin
                    errors++;
                    $display("[TB] FAIL toggle read_en cyc=%0d got=%b exp=%b", c, read_en, er);
                end
            end
            if (wire_conn === 2'd0) l0_cycles++;
            if (done === 1'b1) done_cyc = c;
            if (c == 10 || c == 11) begin
                checks++;
                if (row_idx !== ((c == 10) ? 2'd0 : 2'd1)) begin
                    errors++;
                    $display("[TB] FAIL toggle row cyc=%0d got=%0d", c, row_idx);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (l0_cycles != 16) begin
            errors++;
            $display("[TB] FAIL toggle l0_len got=%0d exp=16", l0_cycles);
        end
        checks++;
        if (done_cyc != 35) begin
            errors++;
            $display("[TB] FAIL toggle done_cycle got=%0d exp=35", done_cyc);
        end
`ifdef LAYER_SEQ_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd8) begin
            errors++;
            $display("[TB] FAIL toggle stall_cnt got=%0d exp=8", stall_cnt);
        end
`endif
    endtask

    // Downstream holds off for five DRAIN cycles.
    task automatic test_drain_stall();
        int exp_done_q[$];
        int e;
        exp_done_q.push_back(32);
        for (int c = 0; c <= 33; c++) begin
            @(posedge clk);
            #1;
            start    = (c == 0);
            data_vld = 1'b1;
            out_rdy  = !(c >= 25 && c <= 29);
            #1;
            if (c >= 25 && c <= 32) begin
                checks++;
                if (out_vld !== (c <= 31)) begin
                    errors++;
                    $display("[TB] FAIL drain out_vld cyc=%0d got=%b exp=%b", c, out_vld, c <= 31);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL drain done cyc=%0d got=1 exp=0", c);
                end else begin
                    e = exp_done_q.pop_front();
                    if (c != e) begin
                        errors++;
                        $display("[TB] FAIL drain done_cycle got=%0d exp=%0d", c, e);
                    end
                end
            end
        end
        start = 1'b0;
        checks++;
        if (exp_done_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain no_done got=none exp=32");
        end
`ifdef LAYER_SEQ_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd5) begin
            errors++;
            $display("[TB] FAIL drain stall_cnt got=%0d exp=5", stall_cnt);
        end
`endif
    endtask

    // Single-layer instance: L0_ROUND goes straight to DRAIN.
    task automatic test_single_layer();
        int exp_done_q[$];
        int e;
        exp_done_q.push_back(16);
        for (int c = 0; c <= 17; c++) begin
            @(posedge clk);
            #1;
            start1   = (c == 0);
            data_vld = 1'b1;
            out_rdy  = 1'b1;
            #1;
            checks++;
            if (wire_conn1 === 2'd2 || layer_idx1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single wire/layer cyc=%0d got=%0d/%0d exp=!2/0",
                         c, wire_conn1, layer_idx1);
            end
            if (c == 14 || c == 15) begin
                checks++;
                if (out_vld1 !== 1'b1 || wire_conn1 !== 2'd3) begin
                    errors++;
                    $display("[TB] FAIL single drain cyc=%0d got vld=%b wire=%0d exp=1/3",
                             c, out_vld1, wire_conn1);
                end
            end
            if (done1 === 1'b1) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL single done cyc=%0d got=1 exp=0", c);
                end else begin
                    e = exp_done_q.pop_front();
                    if (c != e) begin
                        errors++;
                        $display("[TB] FAIL single done_cycle got=%0d exp=%0d", c, e);
                    end
                end
            end
        end
        start1 = 1'b0;
        checks++;
        if (exp_done_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL single no_done got=none exp=16");
        end
    endtask

    // Reset asserted mid LN_NORMAL must clear outputs without a clock edge.
    task automatic test_async_reset();
        for (int c = 0; c <= 17; c++) begin
            @(posedge clk);
            #1;
            start    = (c == 0);
            data_vld = 1'b1;
            out_rdy  = 1'b1;
        end
        start = 1'b0;
        #1;
        checks++;
        if (wire_conn !== 2'd2 || layer_idx !== 2'd1) begin
            errors++;
            $display("[TB] FAIL areset pre got wire=%0d layer=%0d exp=2/1", wire_conn, layer_idx);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, read_en, data_rdy, acc_clr, out_vld, done} !== 6'b0 || wire_conn !== 2'd3) begin
            errors++;
            $display("[TB] FAIL areset outputs got ctrl=%b wire=%0d exp=000000/3",
                     {busy, read_en, data_rdy, acc_clr, out_vld, done}, wire_conn);
        end
        checks++;
        if (layer_idx !== '0 || row_idx !== '0) begin
            errors++;
            $display("[TB] FAIL areset idx got layer=%0d row=%0d exp=0", layer_idx, row_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        test_nominal(-1, "rerun");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        start1   = 1'b0;
        data_vld = 1'b0;
        out_rdy  = 1'b0;
        $display("[TB] layer_seq_ctrl bench starting");
        test_reset();
        test_nominal(-1, "nominal");
        test_vld_toggle();
        test_drain_stall();
        test_single_layer();
        test_async_reset();
        test_nominal(6, "start_ignored");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
